// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver feeding a small show-ahead receive FIFO.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clkRx,
    input  logic                 resetreg,
    input  logic                 serialInput,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 fifo_full,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DLAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] SLAST = IW'(STOP_BITS - 1);
    localparam logic [AW:0]   FULLC = (AW + 1)'(FIFO_DEPTH);
    localparam logic          ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rx;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;

    logic bit_end;
    logic stop_ok;
    logic fe_set;
    logic push;
    logic pop;
    logic wr;
    logic ov_set;

    assign bit_end = (cnt == LAST);
    assign stop_ok = (state == STOP) && bit_end && rx && (idx == SLAST);
    assign fe_set  = (state == STOP) && bit_end && !rx;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic pe_set;

    assign pe_set = (state == PARITY) && bit_end &&
                    (rx != ((^shift) ^ ODD));
    assign push   = stop_ok && !par_bad;

    // Sticky parity error; a new error wins over a clear.
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) parity_err <= 1'b0;
        else parity_err <= (parity_err & ~err_clr) | pe_set;
    end
`else
    assign push       = stop_ok;
    assign parity_err = ODD & 1'b0;
`endif

    assign pop        = rd_en && (count != '0);
    assign wr         = push && ((count != FULLC) || pop);
    assign ov_set     = push && (count == FULLC) && !pop;
    assign data_valid = (count != '0);
    assign fifo_full  = (count == FULLC);
    assign data_out   = data_valid ? mem[rd_ptr] : '0;

    // Two-flop synchroniser, preset to the idle level.
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= serialInput;
            rx    <= sync1;
        end
    end

    // Frame FSM: start validation, data shift, parity and stop checks.
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx) begin
                        // The detect cycle is the first start-bit cycle.
                        state <= START;
                        cnt   <= CW'(1);
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!rx) begin
                            state <= DATA;
`ifdef UART_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= {rx, shift[DATA_BITS-1:1]};
                        if (idx == DLAST) begin
                            idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
`ifdef UART_RX_PARITY_EN
                        par_bad <= (rx != ((^shift) ^ ODD));
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (!rx) begin
                            state <= RECOVER;
                            idx   <= '0;
                        end else if (idx == SLAST) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    cnt <= '0;
                    idx <= '0;
                    if (rx) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky frame and overrun errors; a new error wins over a clear.
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= (frame_err & ~err_clr) | fe_set;
            overrun_err <= (overrun_err & ~err_clr) | ov_set;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop) count <= count + 1'b1;
            else if (!wr && pop) count <= count - 1'b1;
        end
    end

    // FIFO storage; contents are masked by count so need no reset.
    always_ff @(posedge clkRx) begin
        if (wr) mem[wr_ptr] <= shift;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Build with UART_RX_PARITY_EN to add the parity cases.
module tb_uart_rx_fifo;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NP = 1;
`else
    localparam int NP = 0;
`endif
    localparam int LAT = 2 + (CPB - 1) / 2 + (8 + NP + 1) * CPB + 1;

    logic       clkRx;
    logic       resetreg;
    logic       serialInput;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       fifo_full;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int rise_cyc = 0;
    int pop_at = 0;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .STOP_BITS(1),
        .FIFO_DEPTH(4),
        .PARITY_ODD(0)
    ) dut (
        .clkRx(clkRx),
        .resetreg(resetreg),
        .serialInput(serialInput),
        .rd_en(rd_en),
        .err_clr(err_clr),
        .data_out(data_out),
        .data_valid(data_valid),
        .fifo_full(fifo_full),
        .frame_err(frame_err),
        .overrun_err(overrun_err),
        .parity_err(parity_err)
    );

    initial clkRx = 1'b0;
    always #5 clkRx = ~clkRx;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        serialInput = v;
        for (int j = 0; j < CPB; j++) begin
            @(negedge clkRx);
            k++;
            if (data_valid && rise_cyc == 0) rise_cyc = k;
            rd_en = (k == pop_at - 1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d,
                              input logic stop_v,
                              input logic par_flip);
        logic p;
        p = (^d) ^ par_flip;
        k = 0;
        rise_cyc = 0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (NP == 1) send_bit(p);
        send_bit(stop_v);
    endtask

    task automatic idle(input int n);
        serialInput = 1'b1;
        repeat (n) @(negedge clkRx);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clkRx);
        rd_en = 1'b0;
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        @(negedge clkRx);
        err_clr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dv"}, {31'd0, data_valid}, 32'd0);
        check({tag, "_do"}, {24'd0, data_out}, 32'd0);
        check({tag, "_full"}, {31'd0, fifo_full}, 32'd0);
        check({tag, "_fe"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_ov"}, {31'd0, overrun_err}, 32'd0);
        check({tag, "_pe"}, {31'd0, parity_err}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        resetreg    = 1'b1;
        serialInput = 1'b1;
        rd_en       = 1'b0;
        err_clr     = 1'b0;
        repeat (3) @(negedge clkRx);
        check_zero("rst");
        resetreg = 1'b0;
        idle(4);

        send_frame(8'hA5, 1'b1, 1'b0);
        check("t1_lat", rise_cyc, LAT);
        check("t1_dv", {31'd0, data_valid}, 32'd1);
        check("t1_do", {24'd0, data_out}, 32'hA5);
        idle(2);
        pop_one();
        check("t1_pop_dv", {31'd0, data_valid}, 32'd0);
        check("t1_pop_do", {24'd0, data_out}, 32'd0);

        serialInput = 1'b0;
        repeat (4) @(negedge clkRx);
        idle(30);
        check("t2_glitch_dv", {31'd0, data_valid}, 32'd0);
        check("t2_glitch_fe", {31'd0, frame_err}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(2);
        check("t2_do", {24'd0, data_out}, 32'h5A);
        pop_one();

        send_frame(8'h3C, 1'b0, 1'b0);
        check("t3_fe", {31'd0, frame_err}, 32'd1);
        check("t3_nopush", {31'd0, data_valid}, 32'd0);
        serialInput = 1'b0;
        repeat (100) @(negedge clkRx);
        idle(30);
        check("t3_brk_dv", {31'd0, data_valid}, 32'd0);
        check("t3_brk_fe", {31'd0, frame_err}, 32'd1);
        clr_err();
        check("t3_clr", {31'd0, frame_err}, 32'd0);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(2);
        check("t3_do", {24'd0, data_out}, 32'h55);
        check("t3_fe2", {31'd0, frame_err}, 32'd0);
        pop_one();

        for (int i = 1; i <= 5; i++) begin
            v = 8'(i);
            send_frame(v, 1'b1, 1'b0);
            idle(4);
            if (i == 3) check("t4_full3", {31'd0, fifo_full}, 32'd0);
            if (i == 4) begin
                check("t4_full4", {31'd0, fifo_full}, 32'd1);
                check("t4_ov4", {31'd0, overrun_err}, 32'd0);
            end
        end
        check("t4_ov5", {31'd0, overrun_err}, 32'd1);
        check("t4_full5", {31'd0, fifo_full}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("t4_rd", {24'd0, data_out}, 32'(i));
            pop_one();
        end
        check("t4_empty", {31'd0, data_valid}, 32'd0);
        clr_err();
        check("t4_ovclr", {31'd0, overrun_err}, 32'd0);

        send_frame(8'h11, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h33, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h44, 1'b1, 1'b0);
        idle(4);
        pop_at = LAT;
        send_frame(8'h66, 1'b1, 1'b0);
        pop_at = 0;
        rd_en = 1'b0;
        idle(4);
        check("t4b_ov", {31'd0, overrun_err}, 32'd0);
        check("t4b_full", {31'd0, fifo_full}, 32'd1);
        check("t4b_h0", {24'd0, data_out}, 32'h22);
        pop_one();
        check("t4b_h1", {24'd0, data_out}, 32'h33);
        pop_one();
        check("t4b_h2", {24'd0, data_out}, 32'h44);
        pop_one();
        check("t4b_h3", {24'd0, data_out}, 32'h66);
        pop_one();
        check("t4b_empty", {31'd0, data_valid}, 32'd0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        check("t5_pe", {31'd0, parity_err}, 32'd1);
        check("t5_nopush", {31'd0, data_valid}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        check("t5_do", {24'd0, data_out}, 32'h07);
        check("t5_fe", {31'd0, frame_err}, 32'd0);
        pop_one();
        clr_err();
        check("t5_clr", {31'd0, parity_err}, 32'd0);
`endif

        send_frame(8'h99, 1'b1, 1'b0);
        idle(4);
        check("t6_pre", {31'd0, data_valid}, 32'd1);
        k = 0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        serialInput = 1'b0;
        repeat (8) @(negedge clkRx);
        resetreg = 1'b1;
        #1;
        check_zero("t6_rst");
        @(negedge clkRx);
        serialInput = 1'b1;
        @(negedge clkRx);
        resetreg = 1'b0;
        idle(200);
        check("t6_nopartial", {31'd0, data_valid}, 32'd0);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(4);
        check("t6_do", {24'd0, data_out}, 32'hC3);
        check("t6_dv", {31'd0, data_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the team's fixed 8N1 receiver. Configurable bit period, data width and stop-bit count, with glitch rejection on the start bit and framing/overrun error flags. Received words go into a small show-ahead FIFO that the consumer drains with a read strobe. Sits between the serial pin and the core's I/O register block.

Parameters:
CLKS_PER_BIT, 16, clkRx cycles per serial bit; legal range >= 4.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
STOP_BITS, 1, stop bits checked per frame; legal values 1 or 2.
FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; only used with UART_RX_PARITY_EN.

Ports:
clkRx  in  1  receiver clock; all logic is on the rising edge.
resetreg  in  1  asynchronous, active-high reset.
serialInput  in  1  asynchronous serial line; idles high.
rd_en  in  1  pops the FIFO head when data_valid=1.
err_clr  in  1  one-cycle pulse that clears the sticky error flags.
data_out  out  DATA_BITS  FIFO head word; 0 when the FIFO is empty.
data_valid  out  1  FIFO is not empty.
fifo_full  out  1  FIFO holds FIFO_DEPTH words.
frame_err  out  1  sticky: a stop bit was sampled low.
overrun_err  out  1  sticky: a word was dropped because the FIFO was full.
parity_err  out  1  sticky: parity mismatch (tied to 0 without the macro).

Behaviour:
- Reset: resetreg is asynchronous, active-high; clock is clkRx.
  - All outputs are 0. The FIFO is emptied. The FSM goes to IDLE. Counters are 0. The synchroniser flops are preset to 1.
  - Reset asserted mid-frame abandons the frame immediately; no partial word is pushed.
- Input path: serialInput passes through a 2-FF synchroniser. The FSM only ever sees the synchronised value rx.
- State IDLE: bit counter and index are held at 0. When rx==0, go to START.
- State START: the counter increments each cycle. At count (CLKS_PER_BIT-1)/2:
  - rx==0: clear the counter and go to DATA.
  - rx==1: glitch; go back to IDLE.
- State DATA: when the counter reaches CLKS_PER_BIT-1 (the middle of a bit), sample rx into shift[index] and clear the counter.
  - After DATA_BITS samples, go to PARITY if the macro is defined, otherwise to STOP.
- State STOP: sample at each bit middle, STOP_BITS times.
  - Any stop sample of 0: set frame_err, discard the word, go to RECOVER.
  - All stop samples 1 and no parity error: push the word in the same cycle, then go to IDLE.
- State RECOVER: wait until rx==1, then go to IDLE. This stops a held-low break from being taken as repeated frames.
- FIFO behaviour:
  - Show-ahead: data_out is the head word. A pushed word is visible, with data_valid=1, on the edge after the push.
  - rd_en while empty is ignored.
  - Push while full with no pop: the word is dropped and overrun_err is set.
  - Push and pop in the same cycle while full: both take effect; no overrun.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. A separate count register drives full and empty.
- Error flags:
  - frame_err, overrun_err and parity_err stay set until err_clr.
  - If a new error and err_clr occur in the same cycle, the flag ends up set.
- Latency: from the serialInput falling edge to data_valid is 2 + (CLKS_PER_BIT-1)/2 + (DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT + 1 cycles, where P = 1 with parity and 0 without.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - State PARITY samples one extra bit between the data bits and the stop bits.
  - Expected parity is the XOR of the data bits, inverted when PARITY_ODD=1.
  - On mismatch: set parity_err, discard the word, still check the stop bits (a frame error can also be flagged).
- Not defined: there is no PARITY state, parity_err is constant 0, and PARITY_ODD is ignored.

Test Plan:
All cases use CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4.
1. Send frame 0xA5 → data_valid=1 and data_out=0xA5 at the computed latency; pulse rd_en → data_valid=0 and data_out=0.
2. Drive serialInput low for 4 cycles, then high → no push, data_valid stays 0, FSM back in IDLE; a following 0x5A frame is received correctly.
3. Send 0x3C with its stop bit low → frame_err=1, no push; hold the line low for 100 cycles, then release → no push; pulse err_clr → frame_err=0; send 0x55 → received.
4. Send 0x01..0x05 with no rd_en → fifo_full=1 after 0x04, overrun_err=1 after 0x05; four reads return 0x01, 0x02, 0x03, 0x04.
5. Macro defined, PARITY_ODD=0: send 0x07 with parity bit 0 → parity_err=1, no push; send 0x07 with parity bit 1 → data_out=0x07.
6. Assert resetreg during data bit 3 of 0xC3 → all outputs 0 immediately and FIFO empty; release, send a full 0xC3 → data_out=0xC3.
